// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I fetch stage, PC register, one-deep imem request,
// one-entry valid/ready instruction register toward decode.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   imem_req_valid/addr     read request (word aligned), imem_req_ready accept
//   imem_rsp_valid/data/err read response (err = access fault)
//   redirect_valid/pc       restart fetch at redirect_pc (low bits dropped)
//   instr_valid/word/pc/fault, instr_ready  output to decode
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr_word,
  output logic [31:0] instr_pc,
  output logic        instr_fault,
  input  logic        instr_ready
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DROP
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] redir_pc;

  assign redir_pc       = {redirect_pc[31:2], 2'b00};
  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= {RESET_PC[31:2], 2'b00};
      instr_valid <= 1'b0;
      instr_word  <= 32'h0;
      instr_pc    <= 32'h0;
      instr_fault <= 1'b0;
    end else if (redirect_valid) begin
      // An already accepted request still owes a response;
      // DROP swallows it before the new address goes out.
      pc          <= redir_pc;
      instr_valid <= 1'b0;
      unique case (state)
        REQ:     state <= imem_req_ready ? DROP : REQ;
        WAIT:    state <= imem_rsp_valid ? REQ : DROP;
        DROP:    state <= imem_rsp_valid ? REQ : DROP;
        default: state <= REQ;
      endcase
    end else begin
      unique case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (imem_req_ready) state <= WAIT;
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            instr_word  <= imem_rsp_data;
            instr_pc    <= pc;
            instr_fault <= imem_rsp_err;
            instr_valid <= 1'b1;
            pc          <= pc + 32'd4;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (instr_valid && instr_ready) begin
            instr_valid <= 1'b0;
            state       <= REQ;
          end
        end
        DROP: begin
          if (imem_rsp_valid) state <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed cycle table plus randomized run
// against a program-order model of the fetch stream.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr_word;
  logic [31:0] instr_pc;
  logic        instr_fault;
  logic        instr_ready;

  instr_fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_word     (instr_word),
    .instr_pc       (instr_pc),
    .instr_fault    (instr_fault),
    .instr_ready    (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rr;
    logic        rv;
    logic [31:0] rd;
    logic        re;
    logic        dv;
    logic [31:0] dp;
    logic        ir;
    logic [98:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   nvec;
  int   nerr;

  function automatic vec_t mk(
    input logic rst, input logic rr, input logic rv,
    input logic [31:0] rd, input logic re,
    input logic dv, input logic [31:0] dp, input logic ir,
    input logic erv, input logic [31:0] era,
    input logic eiv, input logic [31:0] ew,
    input logic [31:0] ep, input logic ef);
    vec_t v;
    v.rst = rst; v.rr = rr; v.rv = rv; v.rd = rd; v.re = re;
    v.dv = dv; v.dp = dp; v.ir = ir;
    v.exp = {erv, era, eiv, ew, ep, ef};
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return a[5:2] == 4'hF;
  endfunction

  logic [98:0] act;
  logic [31:0] exp_pc;
  logic [31:0] maddr;
  logic [31:0] p_w;
  logic [31:0] p_pc;
  logic        p_f;
  logic        prev_hold;
  logic        busy;
  logic        dv;
  logic        ir;
  logic        rr;
  logic [31:0] dp;
  int          lat;
  int          ndeliv;

  initial begin
    nvec = 0;
    nerr = 0;
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    imem_rsp_err = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;

    // rst rr rv rd re dv dp ir | req_v addr iv word pc fault
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(1,0,1,32'h0050_0093,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,1, 0,4,1,32'h0050_0093,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,0,0, 1,4,0,32'h0050_0093,0,0));
    tbl.push_back(mk(1,0,1,32'h13,0,0,0,0, 0,4,0,32'h0050_0093,0,0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,8,1,32'h13,4,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,1, 0,8,1,32'h13,4,0));
    tbl.push_back(mk(1,1,0,0,0,0,0,0, 1,8,0,32'h13,4,0));
    tbl.push_back(mk(1,0,0,0,0,1,32'h102,0, 0,8,0,32'h13,4,0));
    tbl.push_back(mk(1,0,1,32'hDEAD_BEEF,0,0,0,0, 0,32'h100,0,32'h13,4,0));
    tbl.push_back(mk(1,1,0,0,0,0,0,0, 1,32'h100,0,32'h13,4,0));
    tbl.push_back(mk(1,0,1,32'hBAD,0,1,32'h200,0, 0,32'h100,0,32'h13,4,0));
    tbl.push_back(mk(1,0,0,0,0,1,32'h40,0, 1,32'h200,0,32'h13,4,0));
    tbl.push_back(mk(1,1,0,0,0,0,0,0, 1,32'h40,0,32'h13,4,0));
    tbl.push_back(mk(1,0,1,32'h73,1,0,0,0, 0,32'h40,0,32'h13,4,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,1, 0,32'h44,1,32'h73,32'h40,1));
    tbl.push_back(mk(1,1,0,0,0,1,32'hFFFF_FFFF,0,
                     1,32'h44,0,32'h73,32'h40,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,
                     0,32'hFFFF_FFFC,0,32'h73,32'h40,1));
    tbl.push_back(mk(1,0,1,0,0,0,0,0,
                     0,32'hFFFF_FFFC,0,32'h73,32'h40,1));
    tbl.push_back(mk(1,1,0,0,0,0,0,0,
                     1,32'hFFFF_FFFC,0,32'h73,32'h40,1));
    tbl.push_back(mk(1,0,1,32'h1111_1111,0,0,0,0,
                     0,32'hFFFF_FFFC,0,32'h73,32'h40,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,1,
                     0,0,1,32'h1111_1111,32'hFFFF_FFFC,0));
    tbl.push_back(mk(1,1,0,0,0,0,0,0,
                     1,0,0,32'h1111_1111,32'hFFFF_FFFC,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(1,0,1,32'h2222_2222,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,1,32'h300,1, 0,4,1,32'h2222_2222,0,0));
    tbl.push_back(mk(1,0,1,32'h99,0,0,0,0, 1,32'h300,0,32'h2222_2222,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,32'h300,0,32'h2222_2222,0,0));

    repeat (3) @(negedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n = tbl[i].rst;
      imem_req_ready = tbl[i].rr;
      imem_rsp_valid = tbl[i].rv;
      imem_rsp_data = tbl[i].rd;
      imem_rsp_err = tbl[i].re;
      redirect_valid = tbl[i].dv;
      redirect_pc = tbl[i].dp;
      instr_ready = tbl[i].ir;
      #1;
      act = {imem_req_valid, imem_req_addr, instr_valid,
             instr_word, instr_pc, instr_fault};
      nvec++;
      if (act !== tbl[i].exp) begin
        nerr++;
        $display("FAIL row%0d got %h want %h", i, act, tbl[i].exp);
      end
    end

    // Randomized run: memory with 1..3 cycle latency, random
    // back-pressure and redirects; delivered stream checked
    // against program order.
    @(negedge clk);
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = 32'h0;
    busy = 1'b0;
    prev_hold = 1'b0;
    ndeliv = 0;
    lat = 0;
    maddr = 32'h0;
    p_w = 32'h0;
    p_pc = 32'h0;
    p_f = 1'b0;

    repeat (4000) begin
      @(negedge clk);
      if (prev_hold) begin
        nvec++;
        if (!(instr_valid && instr_word == p_w &&
              instr_pc == p_pc && instr_fault == p_f)) begin
          nerr++;
          $display("FAIL stable got v%0b %h %h %0b want v1 %h %h %0b",
                   instr_valid, instr_word, instr_pc, instr_fault,
                   p_w, p_pc, p_f);
        end
      end
      if (imem_req_valid) begin
        nvec++;
        if (busy || imem_req_addr[1:0] != 2'b00) begin
          nerr++;
          $display("FAIL req got busy%0b addr %h want idle aligned",
                   busy, imem_req_addr);
        end
      end

      imem_rsp_valid = 1'b0;
      if (busy) begin
        lat--;
        if (lat == 0) begin
          imem_rsp_valid = 1'b1;
          busy = 1'b0;
        end
      end
      imem_rsp_data = mem_word(maddr);
      imem_rsp_err = mem_err(maddr);

      rr = ($urandom_range(0, 2) != 0);
      imem_req_ready = rr;
      if (imem_req_valid && rr) begin
        busy = 1'b1;
        maddr = imem_req_addr;
        lat = $urandom_range(1, 3);
      end

      dv = ($urandom_range(0, 15) == 0);
      dp = $urandom_range(0, 32'h3FF);
      if ($urandom_range(0, 3) == 0) dp = dp | 32'hFFFF_FF00;
      ir = ($urandom_range(0, 3) != 0);
      redirect_valid = dv;
      redirect_pc = dp;
      instr_ready = ir;

      if (dv) begin
        exp_pc = dp & 32'hFFFF_FFFC;
      end else if (instr_valid && ir) begin
        nvec++;
        ndeliv++;
        if (instr_pc != exp_pc || instr_word != mem_word(exp_pc) ||
            instr_fault != mem_err(exp_pc)) begin
          nerr++;
          $display("FAIL deliver got %h %h %0b want %h %h %0b",
                   instr_pc, instr_word, instr_fault,
                   exp_pc, mem_word(exp_pc), mem_err(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
      end

      prev_hold = instr_valid && !ir && !dv;
      p_w = instr_word;
      p_pc = instr_pc;
      p_f = instr_fault;
    end

    nvec++;
    if (ndeliv < 100) begin
      nerr++;
      $display("FAIL progress got %0d delivered want >= 100", ndeliv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
